// File: rtl/pe_layer_sequencer.sv
// pe_layer_sequencer: walks each layer, issuing input-activation then write-back indices per PE.
module pe_layer_sequencer #(
  parameter int PE_IDX  = 0,
  parameter int LAYER_W = 3,
  parameter int ACT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_no,
  input  logic [ACT_W-1:0]   in_act_no,
  input  logic [ACT_W-1:0]   out_act_no,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               act_valid,
  input  logic               act_ready,
  output logic [ACT_W-1:0]   act_idx,
  input  logic               mac_idle,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [ACT_W-1:0]   wb_idx,
  output logic               busy,
  output logic               layer_done,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, WB, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
  logic [ACT_W-1:0] act_idx_q, act_idx_d, wb_idx_q, wb_idx_d;
  logic [ACT_W-1:0] in_lim_q, in_lim_d, out_lim_q, out_lim_d;
  logic act_last, wb_last, layer_last;
  assign act_last = act_idx_q == in_lim_q - ACT_W'(1);
  assign wb_last = wb_idx_q == out_lim_q - ACT_W'(1);
  // the all-ones guard keeps layer_idx+1 inside the state-reg lookup range
  assign layer_last = (layer_idx_q == layer_no - LAYER_W'(1)) || (&layer_idx_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      layer_idx_q <= '0;
      act_idx_q   <= '0;
      wb_idx_q    <= '0;
      in_lim_q    <= '0;
      out_lim_q   <= '0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      act_idx_q   <= act_idx_d;
      wb_idx_q    <= wb_idx_d;
      in_lim_q    <= in_lim_d;
      out_lim_q   <= out_lim_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    act_idx_d   = act_idx_q;
    wb_idx_d    = wb_idx_q;
    in_lim_d    = in_lim_q;
    out_lim_d   = out_lim_q;
    case (state_q)
      IDLE: begin
        layer_idx_d = '0;
        if (start) state_d = (layer_no == '0) ? FIN : LOAD;
      end
      LOAD: begin
        in_lim_d  = in_act_no;
        out_lim_d = out_act_no;
        act_idx_d = '0;
        wb_idx_d  = '0;
        state_d   = (in_act_no != '0) ? ISSUE : DRAIN;
      end
      ISSUE: if (act_ready) begin
        state_d   = act_last ? DRAIN : ISSUE;
        act_idx_d = act_last ? act_idx_q : act_idx_q + ACT_W'(1);
      end
      DRAIN: if (mac_idle) state_d = (out_lim_q != '0) ? WB : NEXT;
      WB: if (wb_ready) begin
        state_d  = wb_last ? NEXT : WB;
        wb_idx_d = wb_last ? wb_idx_q : wb_idx_q + ACT_W'(1);
      end
      NEXT: begin
        state_d     = layer_last ? FIN : LOAD;
        layer_idx_d = layer_last ? layer_idx_q : layer_idx_q + LAYER_W'(1);
      end
      FIN: begin
        state_d     = IDLE;
        layer_idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    layer_idx  = layer_idx_q;
    act_idx    = act_idx_q;
    wb_idx     = wb_idx_q;
    act_valid  = state_q == ISSUE;
    wb_valid   = state_q == WB;
    busy       = state_q != IDLE;
    layer_done = state_q == NEXT;
    done       = state_q == FIN;
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && state_q == LOAD)
      $display("[pe%0d] load layer %0d in=%0d out=%0d", PE_IDX, layer_idx_q, in_act_no, out_act_no);
    if (!rst && state_q == FIN)
      $display("[pe%0d] network run complete", PE_IDX);
  end
`endif
endmodule
